// File: rtl/pipeline_stage_reg.sv
// Pipeline stage register with flush, hold, a counted squash window and bubble statistics.
// Ports:
//   clk, reset
//     Clock and synchronous active-high reset.
//   hold, flush
//     Freeze the stage contents, or replace them with a bubble.
//   squash_load, squash_cnt_in
//     Arm the squash counter with the number of captures to discard.
//   valid_in, data_in, ctrl_in
//     Upstream entry.
//   valid_out, data_out, ctrl_out
//     Registered entry.
//   squash_remaining, squash_pending
//     Current squash count, and a flag that is high while it is non-zero.
//   bubble_cnt
//     Saturating count of the edges on which a bubble was inserted.
module pipeline_stage_reg #(
   parameter int DATA_W     = 64,
   parameter int CTRL_W     = 16,
   parameter int SQUASH_MAX = 3,
   parameter int CNT_W      = 16,
   localparam int SQ_W      = $clog2(SQUASH_MAX + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              flush,
   input  logic              squash_load,
   input  logic [SQ_W-1:0]   squash_cnt_in,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [SQ_W-1:0]   squash_remaining,
   output logic              squash_pending,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [SQ_W-1:0] SQ_MAX_V = SQ_W'(SQUASH_MAX);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [SQ_W-1:0]   sq_rem_q, sq_rem_d;
   logic [CNT_W-1:0]  bub_q, bub_d;

   logic              squash_act;
   logic              bubble_act;
   logic [SQ_W-1:0]   sq_load_val;

   // The edge action is chosen from the pre-edge counter value.
   assign squash_act = !flush && !hold && (sq_rem_q != '0);
   assign bubble_act = flush || squash_act;

   // The load value is clamped to the largest armable count.
   assign sq_load_val = (squash_cnt_in > SQ_MAX_V) ? SQ_MAX_V
                                                   : squash_cnt_in;

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      ctrl_d   = ctrl_q;
      sq_rem_d = sq_rem_q;
      bub_d    = bub_q;

      if (bubble_act) begin
         valid_d = 1'b0;
         data_d  = '0;
         ctrl_d  = '0;
      end else if (!hold) begin
         valid_d = valid_in;
         data_d  = data_in;
         ctrl_d  = ctrl_in;
      end

      if (squash_act) begin
         sq_rem_d = sq_rem_q - SQ_W'(1);
      end

      // A load wins over both the decrement and a hold on the same edge.
      if (squash_load) begin
         sq_rem_d = sq_load_val;
      end

      if (bubble_act && (bub_q != '1)) begin
         bub_d = bub_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         ctrl_q   <= '0;
         sq_rem_q <= '0;
         bub_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         ctrl_q   <= ctrl_d;
         sq_rem_q <= sq_rem_d;
         bub_q    <= bub_d;
      end
   end

   assign valid_out        = valid_q;
   assign data_out         = data_q;
   assign ctrl_out         = ctrl_q;
   assign squash_remaining = sq_rem_q;
   assign squash_pending   = (sq_rem_q != '0);
   assign bubble_cnt       = bub_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: a default build and a CNT_W=4 / SQUASH_MAX=5 build
// driven by the same inputs and compared against a behavioural model.
module tb_pipeline_stage_reg;

   logic        clk = 1'b0;
   logic        reset, hold, flush, squash_load, valid_in;
   logic [2:0]  sq_in;
   logic [63:0] data_in;
   logic [15:0] ctrl_in;

   logic        v0, p0, v1, p1;
   logic [63:0] d0, d1;
   logic [15:0] c0, c1, b0;
   logic [1:0]  r0;
   logic [2:0]  r1;
   logic [3:0]  b1;

   logic        vo [2];
   logic [63:0] do_ [2];
   logic [15:0] co [2];
   logic [2:0]  ro [2];
   logic        po [2];
   logic [15:0] bo [2];

   assign vo[0] = v0;  assign vo[1] = v1;
   assign do_[0] = d0; assign do_[1] = d1;
   assign co[0] = c0;  assign co[1] = c1;
   assign ro[0] = {1'b0, r0}; assign ro[1] = r1;
   assign po[0] = p0;  assign po[1] = p1;
   assign bo[0] = b0;  assign bo[1] = {12'b0, b1};

   int n_pass = 0;
   int n_total = 0;

   logic        m_valid [2];
   logic [63:0] m_data [2];
   logic [15:0] m_ctrl [2];
   int          m_rem [2];
   int          m_bub [2];
   int          smax [2];
   int          cap [2];

   always #5 clk = ~clk;

   pipeline_stage_reg dut (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush),
      .squash_load(squash_load), .squash_cnt_in(sq_in[1:0]),
      .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in),
      .valid_out(v0), .data_out(d0), .ctrl_out(c0),
      .squash_remaining(r0), .squash_pending(p0), .bubble_cnt(b0)
   );

   pipeline_stage_reg #(.SQUASH_MAX(5), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush),
      .squash_load(squash_load), .squash_cnt_in(sq_in),
      .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in),
      .valid_out(v1), .data_out(d1), .ctrl_out(c1),
      .squash_remaining(r1), .squash_pending(p1), .bubble_cnt(b1)
   );

   // Advance the model by one edge from the current inputs, then clock the DUTs.
   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         int cin;
         bit sq;
         cin = (k == 0) ? int'(sq_in[1:0]) : int'(sq_in);
         if (reset) begin
            m_valid[k] = 0; m_data[k] = 0; m_ctrl[k] = 0;
            m_rem[k] = 0; m_bub[k] = 0;
         end else begin
            sq = !flush && !hold && (m_rem[k] > 0);
            if (flush || sq) begin
               m_valid[k] = 0; m_data[k] = 0; m_ctrl[k] = 0;
               if (m_bub[k] < cap[k]) m_bub[k] = m_bub[k] + 1;
            end else if (!hold) begin
               m_valid[k] = valid_in; m_data[k] = data_in; m_ctrl[k] = ctrl_in;
            end
            if (sq) m_rem[k] = m_rem[k] - 1;
            if (squash_load) m_rem[k] = (cin > smax[k]) ? smax[k] : cin;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; hold = 0; flush = 0; squash_load = 0; sq_in = 0;
   endtask

   task automatic test_reset();
      reset = 1; hold = 0; flush = 0; squash_load = 1; sq_in = 3;
      valid_in = 1; data_in = 64'hFFFF; ctrl_in = 16'hFF;
      tick();
      n_total++; if (v0 !== 1'b0) $display("FAIL rst_valid got %0h exp 0", v0); else n_pass++;
      n_total++; if (d0 !== 64'h0) $display("FAIL rst_data got %0h exp 0", d0); else n_pass++;
      n_total++; if (c0 !== 16'h0) $display("FAIL rst_ctrl got %0h exp 0", c0); else n_pass++;
      n_total++; if (r0 !== 2'd0) $display("FAIL rst_rem got %0d exp 0", r0); else n_pass++;
      n_total++; if (p0 !== 1'b0) $display("FAIL rst_pend got %0h exp 0", p0); else n_pass++;
      n_total++; if (b0 !== 16'd0) $display("FAIL rst_bub got %0d exp 0", b0); else n_pass++;
      idle();
   endtask

   task automatic test_capture();
      valid_in = 1; data_in = 64'h1234; ctrl_in = 16'h00A5;
      tick();
      n_total++; if (v0 !== 1'b1) $display("FAIL cap_valid got %0h exp 1", v0); else n_pass++;
      n_total++; if (d0 !== 64'h1234) $display("FAIL cap_data got %0h exp 1234", d0); else n_pass++;
      n_total++; if (c0 !== 16'h00A5) $display("FAIL cap_ctrl got %0h exp a5", c0); else n_pass++;
      n_total++; if (b0 !== 16'd0) $display("FAIL cap_bub got %0d exp 0", b0); else n_pass++;
   endtask

   task automatic test_hold();
      hold = 1; data_in = 64'hBEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if (d0 !== 64'h1234) $display("FAIL hold_data[%0d] got %0h exp 1234", i, d0); else n_pass++;
         n_total++; if (c0 !== 16'h00A5) $display("FAIL hold_ctrl[%0d] got %0h exp a5", i, c0); else n_pass++;
         n_total++; if (b0 !== 16'd0) $display("FAIL hold_bub[%0d] got %0d exp 0", i, b0); else n_pass++;
      end
      hold = 0;
   endtask

   task automatic test_flush_squash();
      logic [63:0] seq [3];
      seq[0] = 64'h11; seq[1] = 64'h22; seq[2] = 64'h33;
      flush = 1; squash_load = 1; sq_in = 2;
      tick();
      n_total++; if (v0 !== 1'b0 || d0 !== 64'h0) $display("FAIL fs_flush got v=%0h d=%0h exp 0", v0, d0); else n_pass++;
      n_total++; if (r0 !== 2'd2) $display("FAIL fs_rem0 got %0d exp 2", r0); else n_pass++;
      idle();
      for (int i = 0; i < 3; i++) begin
         data_in = seq[i];
         tick();
         if (i < 2) begin
            n_total++; if (v0 !== 1'b0 || d0 !== 64'h0 || c0 !== 16'h0) $display("FAIL fs_sq[%0d] got v=%0h d=%0h c=%0h exp 0", i, v0, d0, c0); else n_pass++;
            n_total++; if (r0 !== 2'(1 - i)) $display("FAIL fs_rem[%0d] got %0d exp %0d", i, r0, 1 - i); else n_pass++;
         end
      end
      n_total++; if (v0 !== 1'b1 || d0 !== 64'h33) $display("FAIL fs_cap got v=%0h d=%0h exp 1/33", v0, d0); else n_pass++;
      n_total++; if (b0 !== 16'd3) $display("FAIL fs_bub got %0d exp 3", b0); else n_pass++;
   endtask

   task automatic test_squash_clamp();
      squash_load = 1; sq_in = 7;
      tick();
      n_total++; if (r0 !== 2'd3) $display("FAIL clamp_rem got %0d exp 3", r0); else n_pass++;
      n_total++; if (r1 !== 3'd5) $display("FAIL clamp_rem4 got %0d exp 5", r1); else n_pass++;
      squash_load = 0; hold = 1;
      tick(); tick();
      n_total++; if (r0 !== 2'd3 || r1 !== 3'd5) $display("FAIL hold_rem got %0d/%0d exp 3/5", r0, r1); else n_pass++;
      hold = 0;
      tick();
      n_total++; if (r0 !== 2'd2 || r1 !== 3'd4) $display("FAIL dec_rem got %0d/%0d exp 2/4", r0, r1); else n_pass++;
      squash_load = 1; sq_in = 0;
      tick();
      n_total++; if (p0 !== 1'b0 || p1 !== 1'b0) $display("FAIL cancel_pend got %0h/%0h exp 0", p0, p1); else n_pass++;
      idle();
   endtask

   task automatic test_flush_hold();
      int prev;
      valid_in = 1; data_in = 64'h5A5A; ctrl_in = 16'h77;
      tick();
      prev = int'(b0);
      flush = 1; hold = 1;
      tick();
      n_total++; if (v0 !== 1'b0 || d0 !== 64'h0 || c0 !== 16'h0) $display("FAIL fh_out got v=%0h d=%0h c=%0h exp 0", v0, d0, c0); else n_pass++;
      n_total++; if (int'(b0) !== prev + 1) $display("FAIL fh_bub got %0d exp %0d", b0, prev + 1); else n_pass++;
      idle();
   endtask

   task automatic test_saturation();
      reset = 1;
      tick();
      idle();
      flush = 1;
      repeat (14) tick();
      n_total++; if (b1 !== 4'd14) $display("FAIL sat_pre got %0d exp 14", b1); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if (b1 !== 4'd15) $display("FAIL sat[%0d] got %0d exp 15", i, b1); else n_pass++;
      end
      n_total++; if (b0 !== 16'd17) $display("FAIL sat_wide got %0d exp 17", b0); else n_pass++;
      idle();
      squash_load = 1; sq_in = 2;
      tick();
      n_total++; if (r0 !== 2'd2) $display("FAIL rs_rem got %0d exp 2", r0); else n_pass++;
      reset = 1; hold = 1; squash_load = 1; sq_in = 3;
      tick();
      n_total++; if (v0 !== 1'b0 || d0 !== 64'h0 || c0 !== 16'h0 || r0 !== 2'd0 || b0 !== 16'd0) $display("FAIL rs_zero got v=%0h d=%0h c=%0h r=%0d b=%0d exp 0", v0, d0, c0, r0, b0); else n_pass++;
      idle();
      valid_in = 1; data_in = 64'hCAFE; ctrl_in = 16'h1;
      tick();
      n_total++; if (v0 !== 1'b1 || d0 !== 64'hCAFE) $display("FAIL rs_cap got v=%0h d=%0h exp 1/cafe", v0, d0); else n_pass++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 49) == 0);
         hold = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         squash_load = ($urandom_range(0, 7) == 0);
         sq_in = 3'($urandom_range(0, 7));
         valid_in = 1'($urandom);
         data_in = {$urandom, $urandom};
         ctrl_in = 16'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            n_total++; if (vo[k] !== m_valid[k]) $display("FAIL rnd_valid i%0d n%0d got %0h exp %0h", k, n, vo[k], m_valid[k]); else n_pass++;
            n_total++; if (do_[k] !== m_data[k]) $display("FAIL rnd_data i%0d n%0d got %0h exp %0h", k, n, do_[k], m_data[k]); else n_pass++;
            n_total++; if (co[k] !== m_ctrl[k]) $display("FAIL rnd_ctrl i%0d n%0d got %0h exp %0h", k, n, co[k], m_ctrl[k]); else n_pass++;
            n_total++; if (ro[k] !== 3'(m_rem[k])) $display("FAIL rnd_rem i%0d n%0d got %0d exp %0d", k, n, ro[k], m_rem[k]); else n_pass++;
            n_total++; if (po[k] !== (m_rem[k] != 0)) $display("FAIL rnd_pend i%0d n%0d got %0h exp %0h", k, n, po[k], m_rem[k] != 0); else n_pass++;
            n_total++; if (bo[k] !== 16'(m_bub[k])) $display("FAIL rnd_bub i%0d n%0d got %0d exp %0d", k, n, bo[k], m_bub[k]); else n_pass++;
         end
      end
      idle();
   endtask

   initial begin
      smax[0] = 3; smax[1] = 5;
      cap[0] = 65535; cap[1] = 15;
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 0; m_data[k] = 0; m_ctrl[k] = 0; m_rem[k] = 0; m_bub[k] = 0;
      end
      test_reset();
      test_capture();
      test_hold();
      test_flush_squash();
      test_squash_clamp();
      test_flush_hold();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
